lc3_mem_unit: RTL and testbench

- Memory-side stage directly downstream of the LC-3 controller. It owns MAR and MDR and executes the controller's ldMAR/ldMDR/selMDR/memWE/enaMDR strobes.
- Reaches a variable-latency external SRAM through a req/ack handshake, and decodes the memory-mapped I/O page (switches and LEDs).
- Exports mem_ready so a stalling controller can hold its state while an SRAM access is in flight.

---
 rtl/lc3_pkg.sv | 23 ++
 rtl/lc3_mmio_decode.sv | 21 ++
 rtl/lc3_mem_unit.sv | 154 +++++++++++++++
 tb/tb_lc3_mem_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 memory-side stage.
package lc3_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 8;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  // I/O page layout: base of the page and register offsets within it
  localparam word_t MMIO_BASE_DEF = 16'hFE00;
  localparam word_t SW_OFS        = 16'h0000;
  localparam word_t LED_OFS       = 16'h0002;

  // MDR value loaded when an SRAM read is aborted by timeout
  localparam word_t ABORT_VAL     = 16'h0000;

endpackage

// File: rtl/lc3_mmio_decode.sv
// Combinational decode of MAR against the memory-mapped I/O page.
module lc3_mmio_decode
  import lc3_pkg::*;
#(
  parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEF
) (
  input  logic [15:0] addr,
  output logic        is_io,
  output logic        is_sw,
  output logic        is_led
);

  localparam word_t SW_ADDR  = MMIO_BASE + SW_OFS;
  localparam word_t LED_ADDR = MMIO_BASE + LED_OFS;

  // The I/O page runs from the base up to the top of the address space
  assign is_io  = (addr >= MMIO_BASE);
  assign is_sw  = (addr == SW_ADDR);
  assign is_led = (addr == LED_ADDR);

endmodule

// File: rtl/lc3_mem_unit.sv
// LC-3 memory stage: MAR/MDR, SRAM req/ack handshake with timeout, MMIO page.
module lc3_mem_unit
  import lc3_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned TIMEOUT   = 15,
  parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       bus_in,
  input  logic              ldMAR,
  input  logic              ldMDR,
  input  logic              selMDR,
  input  logic              memWE,
  input  logic              enaMDR,
  output logic [15:0]       mdr_out,
  output logic              mdr_oe,
  output logic              mem_ready,
  output logic              sram_req,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_wdata,
  input  logic [15:0]       sram_rdata,
  input  logic              sram_ack,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out,
  output logic              bus_err,
  output logic              cmd_err
);

  state_t            state, state_n;
  word_t             mar, mar_n;
  word_t             mdr, mdr_n;
  word_t             led_n;
  logic              req_n, we_n;
  logic [ADDR_W-1:0] addr_n;
  word_t             wdata_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              bus_err_n, cmd_err_n;
  logic              is_io, is_sw, is_led;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lc3_mmio_decode #(
    .MMIO_BASE (MMIO_BASE)
  ) u_decode (
    .addr   (mar),
    .is_io  (is_io),
    .is_sw  (is_sw),
    .is_led (is_led)
  );

  assign mdr_out   = mdr;
  assign mem_ready = (state == IDLE);
  assign mdr_oe    = enaMDR & mem_ready;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mar        <= '0;
      mdr        <= '0;
      led_out    <= '0;
      sram_req   <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      cnt        <= '0;
      bus_err    <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state      <= state_n;
      mar        <= mar_n;
      mdr        <= mdr_n;
      led_out    <= led_n;
      sram_req   <= req_n;
      sram_we    <= we_n;
      sram_addr  <= addr_n;
      sram_wdata <= wdata_n;
      cnt        <= cnt_n;
      bus_err    <= bus_err_n;
      cmd_err    <= cmd_err_n;
    end
  end

  // Next-state and datapath update; accesses use pre-edge MAR/MDR
  always_comb begin
    state_n   = state;
    mar_n     = mar;
    mdr_n     = mdr;
    led_n     = led_out;
    req_n     = sram_req;
    we_n      = sram_we;
    addr_n    = sram_addr;
    wdata_n   = sram_wdata;
    cnt_n     = cnt;
    bus_err_n = bus_err;
    cmd_err_n = cmd_err;

    case (state)
      IDLE: begin
        if (ldMAR) mar_n = bus_in;
        if (memWE) begin
          // A write wins over a same-edge MDR load, which is dropped
          if (ldMDR) cmd_err_n = 1'b1;
          if (is_led) begin
            led_n = mdr;
          end else if (!is_io) begin
            req_n   = 1'b1;
            we_n    = 1'b1;
            addr_n  = ADDR_W'(mar);
            wdata_n = mdr;
            cnt_n   = '0;
            state_n = WR_WAIT;
          end
        end else if (ldMDR) begin
          if (!selMDR) begin
            mdr_n = bus_in;
          end else if (is_sw) begin
            mdr_n = sw_in;
          end else if (is_io) begin
            mdr_n = '0;
          end else begin
            req_n   = 1'b1;
            we_n    = 1'b0;
            addr_n  = ADDR_W'(mar);
            cnt_n   = '0;
            state_n = RD_WAIT;
          end
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (ldMAR || ldMDR || memWE) cmd_err_n = 1'b1;
        if (sram_ack) begin
          if (state == RD_WAIT) mdr_n = sram_rdata;
          req_n   = 1'b0;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt == CNT_LAST) begin
          if (state == RD_WAIT) mdr_n = ABORT_VAL;
          req_n     = 1'b0;
          bus_err_n = 1'b1;
          cnt_n     = '0;
          state_n   = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lc3_mem_unit.sv
// Directed bench for lc3_mem_unit: vector table for bus/MMIO ops plus SRAM sequences.
module tb_lc3_mem_unit;

  logic        clk;
  logic        reset;
  logic [15:0] bus_in;
  logic        ldMAR, ldMDR, selMDR, memWE, enaMDR;
  logic [15:0] mdr_out;
  logic        mdr_oe, mem_ready;
  logic        sram_req, sram_we;
  logic [15:0] sram_addr, sram_wdata, sram_rdata;
  logic        sram_ack;
  logic [15:0] sw_in, led_out;
  logic        bus_err, cmd_err;

  int tests;
  int fails;

  lc3_mem_unit dut (
    .clk        (clk),
    .reset      (reset),
    .bus_in     (bus_in),
    .ldMAR      (ldMAR),
    .ldMDR      (ldMDR),
    .selMDR     (selMDR),
    .memWE      (memWE),
    .enaMDR     (enaMDR),
    .mdr_out    (mdr_out),
    .mdr_oe     (mdr_oe),
    .mem_ready  (mem_ready),
    .sram_req   (sram_req),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_ack   (sram_ack),
    .sw_in      (sw_in),
    .led_out    (led_out),
    .bus_err    (bus_err),
    .cmd_err    (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ldmar, ldmdr, selmdr, memwe, enamdr;
    logic [15:0] bus, sw;
    logic [15:0] mdr, led;
    logic        rdy, oe, req, cerr;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_in = '0; ldMAR = 0; ldMDR = 0; selMDR = 0; memWE = 0; enaMDR = 0;
    sram_rdata = '0; sram_ack = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    tests = 0;
    fails = 0;
    sw_in = 16'h5A5A;

    //                ldmar ldmdr sel memwe ena  bus       sw        mdr       led       rdy oe req cerr
    vecs[0] = '{1, 0, 0, 0, 0, 16'hFE02, 16'h5A5A, 16'h0000, 16'h0000, 1, 0, 0, 0};
    vecs[1] = '{0, 1, 0, 0, 0, 16'h00A5, 16'h5A5A, 16'h00A5, 16'h0000, 1, 0, 0, 0};
    vecs[2] = '{0, 0, 0, 1, 0, 16'h0000, 16'h5A5A, 16'h00A5, 16'h00A5, 1, 0, 0, 0};
    vecs[3] = '{1, 0, 0, 0, 0, 16'hFE00, 16'h5A5A, 16'h00A5, 16'h00A5, 1, 0, 0, 0};
    vecs[4] = '{0, 1, 1, 0, 0, 16'h0000, 16'h5A5A, 16'h5A5A, 16'h00A5, 1, 0, 0, 0};
    vecs[5] = '{1, 0, 0, 0, 0, 16'hFE10, 16'h1111, 16'h5A5A, 16'h00A5, 1, 0, 0, 0};
    vecs[6] = '{0, 1, 1, 0, 0, 16'h0000, 16'h1111, 16'h0000, 16'h00A5, 1, 0, 0, 0};
    vecs[7] = '{0, 0, 0, 1, 0, 16'h0000, 16'h1111, 16'h0000, 16'h00A5, 1, 0, 0, 0};
    vecs[8] = '{0, 1, 0, 0, 1, 16'hBEEF, 16'h1111, 16'hBEEF, 16'h00A5, 1, 1, 0, 0};
    vecs[9] = '{0, 1, 0, 1, 0, 16'h1234, 16'h1111, 16'hBEEF, 16'h00A5, 1, 0, 0, 1};

    // Reset state
    do_reset();
    chk("rst_mdr", mdr_out, 16'h0000);
    chk("rst_led", led_out, 16'h0000);
    chk("rst_ready", 16'(mem_ready), 16'h1);
    chk("rst_req", 16'(sram_req), 16'h0);
    chk("rst_addr", sram_addr, 16'h0000);
    chk("rst_flags", {14'h0, bus_err, cmd_err}, 16'h0);

    // Single-cycle bus and MMIO operations
    for (int i = 0; i < 10; i++) begin
      ldMAR = vecs[i].ldmar; ldMDR = vecs[i].ldmdr; selMDR = vecs[i].selmdr;
      memWE = vecs[i].memwe; enaMDR = vecs[i].enamdr;
      bus_in = vecs[i].bus; sw_in = vecs[i].sw;
      tick();
      chk($sformatf("v%0d_mdr", i), mdr_out, vecs[i].mdr);
      chk($sformatf("v%0d_led", i), led_out, vecs[i].led);
      chk($sformatf("v%0d_ready", i), 16'(mem_ready), 16'(vecs[i].rdy));
      chk($sformatf("v%0d_oe", i), 16'(mdr_oe), 16'(vecs[i].oe));
      chk($sformatf("v%0d_req", i), 16'(sram_req), 16'(vecs[i].req));
      chk($sformatf("v%0d_cmd_err", i), 16'(cmd_err), 16'(vecs[i].cerr));
    end

    // Async reset mid-read drops req without a clock edge; later ack ignored
    do_reset();
    ldMAR = 1; bus_in = 16'h3000; tick();
    ldMAR = 0; ldMDR = 1; selMDR = 1; tick();
    ldMDR = 0; selMDR = 0;
    chk("ar_req_before", 16'(sram_req), 16'h1);
    #2 reset = 1'b0;
    #1;
    chk("ar_req_async", 16'(sram_req), 16'h0);
    chk("ar_mdr", mdr_out, 16'h0000);
    chk("ar_ready", 16'(mem_ready), 16'h1);
    chk("ar_flags", {14'h0, bus_err, cmd_err}, 16'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    sram_ack = 1; sram_rdata = 16'hDEAD; tick();
    sram_ack = 0;
    chk("ar_ack_mdr", mdr_out, 16'h0000);
    chk("ar_ack_req", 16'(sram_req), 16'h0);
    chk("ar_ack_ready", 16'(mem_ready), 16'h1);

    // SRAM read with ack in the third cycle after the request
    do_reset();
    ldMAR = 1; bus_in = 16'h3000; tick();
    ldMAR = 0; ldMDR = 1; selMDR = 1; tick();
    ldMDR = 0; selMDR = 0;
    chk("rd_addr", sram_addr, 16'h3000);
    chk("rd_we", 16'(sram_we), 16'h0);
    cnt = 0;
    if (!mem_ready) cnt++;
    enaMDR = 1; #1;
    chk("rd_oe_wait", 16'(mdr_oe), 16'h0);
    enaMDR = 0;
    tick(); if (!mem_ready) cnt++;
    tick(); if (!mem_ready) cnt++;
    sram_ack = 1; sram_rdata = 16'h1234; tick();
    sram_ack = 0; sram_rdata = '0;
    chk("rd_low_cycles", 16'(cnt), 16'd3);
    chk("rd_ready", 16'(mem_ready), 16'h1);
    chk("rd_mdr", mdr_out, 16'h1234);
    chk("rd_req", 16'(sram_req), 16'h0);
    enaMDR = 1; #1;
    chk("rd_oe", 16'(mdr_oe), 16'h1);
    enaMDR = 0;

    // SRAM write with no ack times out after TIMEOUT cycles of req
    do_reset();
    ldMAR = 1; bus_in = 16'h4000; tick();
    ldMAR = 0; ldMDR = 1; bus_in = 16'hCAFE; tick();
    ldMDR = 0; memWE = 1; tick();
    memWE = 0;
    chk("to_we", 16'(sram_we), 16'h1);
    chk("to_addr", sram_addr, 16'h4000);
    chk("to_wdata", sram_wdata, 16'hCAFE);
    cnt = 0;
    for (int i = 0; i < 40 && sram_req; i++) begin
      cnt++;
      tick();
    end
    chk("to_req_cycles", 16'(cnt), 16'd15);
    chk("to_bus_err", 16'(bus_err), 16'h1);
    chk("to_ready", 16'(mem_ready), 16'h1);
    chk("to_cmd_err", 16'(cmd_err), 16'h0);

    // Aborted read loads the abort value into MDR
    ldMDR = 1; bus_in = 16'h7777; tick();
    ldMDR = 0; ldMAR = 1; bus_in = 16'h3000; tick();
    ldMAR = 0; ldMDR = 1; selMDR = 1; tick();
    ldMDR = 0; selMDR = 0;
    for (int i = 0; i < 40 && sram_req; i++) tick();
    chk("to_rd_mdr", mdr_out, 16'h0000);

    // Strobe during WR_WAIT is ignored and flagged; write completes unchanged
    do_reset();
    ldMAR = 1; bus_in = 16'h4000; tick();
    ldMAR = 0; ldMDR = 1; bus_in = 16'h1111; tick();
    ldMDR = 0; memWE = 1; tick();
    memWE = 0;
    ldMDR = 1; bus_in = 16'h2222; tick();
    ldMDR = 0;
    chk("ww_mdr", mdr_out, 16'h1111);
    chk("ww_cmd_err", 16'(cmd_err), 16'h1);
    chk("ww_req", 16'(sram_req), 16'h1);
    chk("ww_wdata", sram_wdata, 16'h1111);
    sram_ack = 1; tick();
    sram_ack = 0;
    chk("ww_done_req", 16'(sram_req), 16'h0);
    chk("ww_done_ready", 16'(mem_ready), 16'h1);
    chk("ww_done_mdr", mdr_out, 16'h1111);
    chk("ww_bus_err", 16'(bus_err), 16'h0);

    // Same-edge ldMAR with a read: access uses old MAR, MAR still loads
    do_reset();
    ldMAR = 1; bus_in = 16'h3000; tick();
    bus_in = 16'h5000; ldMDR = 1; selMDR = 1; tick();
    ldMAR = 0; ldMDR = 0; selMDR = 0;
    chk("se_addr", sram_addr, 16'h3000);
    chk("se_req", 16'(sram_req), 16'h1);
    sram_ack = 1; sram_rdata = 16'h0042; tick();
    sram_ack = 0;
    chk("se_mdr", mdr_out, 16'h0042);
    ldMDR = 1; selMDR = 1; tick();
    ldMDR = 0; selMDR = 0;
    chk("se_new_mar", sram_addr, 16'h5000);
    chk("se_cmd_err", 16'(cmd_err), 16'h0);
    sram_ack = 1; tick();
    sram_ack = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
